// File: rtl/mmio_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer_if
// Brief    : Data-memory bus bundle shared by the core and the MMIO timer.
// Revision : 1.0  initial release
// ============================================================================
interface mmio_timer_if;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output MemWrite,
        output Addr,
        output WriteData,
        input  ReadData,
        input  Hit
    );

    modport slave (
        input  MemWrite,
        input  Addr,
        input  WriteData,
        output ReadData,
        output Hit
    );
endinterface
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer
// Brief    : Prescaled 32-bit MMIO timer with compare-match flag and level IRQ.
//            Optional PWM output and DUTY register when TIMER_PWM_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
    parameter int          PRESCALE_W = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mmio_timer_if.slave     bus,
    output logic            Irq
`ifdef TIMER_PWM_EN
    ,
    output logic            pwm_out
`endif
);

    localparam logic [2:0] c_offCtrl     = 3'd0;
    localparam logic [2:0] c_offCount    = 3'd1;
    localparam logic [2:0] c_offCompare  = 3'd2;
    localparam logic [2:0] c_offStatus   = 3'd3;
    localparam logic [2:0] c_offPrescale = 3'd4;
`ifdef TIMER_PWM_EN
    localparam logic [2:0] c_offDuty     = 3'd5;
`endif

    logic                  r_en;
    logic                  r_autoReload;
    logic                  r_irqEn;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic                  r_match;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
`ifdef TIMER_PWM_EN
    logic [31:0]           r_duty;
`endif

    logic                  w_hit;
    logic [2:0]            w_idx;
    logic                  w_wr;
    logic                  w_wrCtrl;
    logic                  w_wrCount;
    logic                  w_wrCompare;
    logic                  w_wrStatus;
    logic                  w_wrPrescale;
    logic                  w_tick;
    logic                  w_matchNow;
    logic [31:0]           w_readData;
    logic                  w_unusedAddr;

    assign w_hit        = (bus.Addr[31:5] == BASE_ADDR[31:5]);
    assign w_idx        = bus.Addr[4:2];
    assign w_unusedAddr = ^bus.Addr[1:0];
    assign w_wr         = bus.MemWrite & w_hit;
    assign w_wrCtrl     = w_wr && (w_idx == c_offCtrl);
    assign w_wrCount    = w_wr && (w_idx == c_offCount);
    assign w_wrCompare  = w_wr && (w_idx == c_offCompare);
    assign w_wrStatus   = w_wr && (w_idx == c_offStatus);
    assign w_wrPrescale = w_wr && (w_idx == c_offPrescale);

    // The compare is always judged on the pre-edge COUNT, even if the bus overwrites it.
    assign w_tick     = r_en && (r_pcnt == r_prescale);
    assign w_matchNow = w_tick && (r_count == r_compare);

    always_comb begin
        w_readData = 32'h0;
        if (w_hit) begin
            case (w_idx)
                c_offCtrl:     w_readData[2:0] = {r_irqEn, r_autoReload, r_en};
                c_offCount:    w_readData = r_count;
                c_offCompare:  w_readData = r_compare;
                c_offStatus:   w_readData[0] = r_match;
                c_offPrescale: w_readData[PRESCALE_W-1:0] = r_prescale;
`ifdef TIMER_PWM_EN
                c_offDuty:     w_readData = r_duty;
`endif
                default:       w_readData = 32'h0;
            endcase
        end
    end

    assign bus.ReadData = w_readData;
    assign bus.Hit      = w_hit;
    assign Irq          = r_match & r_irqEn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en         <= 1'b0;
            r_autoReload <= 1'b0;
            r_irqEn      <= 1'b0;
            r_count      <= 32'h0;
            r_compare    <= 32'hFFFF_FFFF;
            r_match      <= 1'b0;
            r_prescale   <= '0;
            r_pcnt       <= '0;
        end else begin
            if (w_wrCtrl) begin
                r_en         <= bus.WriteData[0];
                r_autoReload <= bus.WriteData[1];
                r_irqEn      <= bus.WriteData[2];
            end

            if (w_wrCompare) begin
                r_compare <= bus.WriteData;
            end

            if (w_wrPrescale) begin
                r_prescale <= bus.WriteData[PRESCALE_W-1:0];
            end

            // Disabling the timer or retuning the prescaler restarts the prescale phase.
            if ((w_wrCtrl && !bus.WriteData[0]) || w_wrPrescale || !r_en || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end

            if (w_wrCount) begin
                r_count <= bus.WriteData;
            end else if (w_tick) begin
                if (w_matchNow && r_autoReload) begin
                    r_count <= 32'h0;
                end else begin
                    r_count <= r_count + 32'd1;
                end
            end

            if (w_matchNow) begin
                r_match <= 1'b1;
            end else if (w_wrStatus && bus.WriteData[0]) begin
                r_match <= 1'b0;
            end
        end
    end

`ifdef TIMER_PWM_EN
    logic w_wrDuty;
    assign w_wrDuty = w_wr && (w_idx == c_offDuty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty  <= 32'h0;
            pwm_out <= 1'b0;
        end else begin
            if (w_wrDuty) begin
                r_duty <= bus.WriteData;
            end
            pwm_out <= r_en & (r_count < r_duty);
        end
    end
`endif

endmodule
`default_nettype wire
